// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t      : FSM encoding (IDLE / RUN / DONE)
//   ADDER_WIDTH  : default operand width
//   calc_cnt_w() : width of the bit counter for a given operand width
package adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int ADDER_WIDTH = 8;

    // Counter only needs to reach WIDTH-1.
    function automatic int calc_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/one_bit_adder.sv
// Full-adder cell built from two half-adder stages.
//   A, B, Cin   : addend bits and carry-in
//   Sum, Cout   : sum bit and carry-out
//   AxorB_out   : propagate term (A ^ B)
//   AandB_out   : generate term (A & B)
//   PandCin_out : propagated carry (P & Cin)
module one_bit_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout,
    output logic AxorB_out,
    output logic AandB_out,
    output logic PandCin_out
);

    logic w_p;
    logic w_g;
    logic w_pc;

    assign w_p         = A ^ B;
    assign w_g         = A & B;
    assign w_pc        = w_p & Cin;
    assign Sum         = w_p ^ Cin;
    assign Cout        = w_g | w_pc;
    assign AxorB_out   = w_p;
    assign AandB_out   = w_g;
    assign PandCin_out = w_pc;

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle WIDTH-bit adder: operands are shifted LSB first through a
// single full-adder cell, one bit per clock, with the carry held in a flop.
//   clk, rst_n             : clock, async active-low reset
//   in_valid / in_ready    : operand handshake (ready only in IDLE)
//   a, b, cin              : operands, sampled on accept
//   out_valid / out_ready  : result handshake (valid held until consumed)
//   sum, cout, overflow    : registered result, carry-out, signed overflow
//   busy                   : high while bits are being processed
module bit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum_sh;
    logic              r_carry;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;
    logic              w_sum;
    logic              w_cout;
    logic              w_last;

    one_bit_adder u_fa (
        .A           (r_a_sh[0]),
        .B           (r_b_sh[0]),
        .Cin         (r_carry),
        .Sum         (w_sum),
        .Cout        (w_cout),
        .AxorB_out   (),
        .AandB_out   (),
        .PandCin_out ()
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_next = ST_RUN;
            ST_RUN:  if (w_last)    w_next = ST_DONE;
            ST_DONE: if (out_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_RUN:  busy      = 1'b1;
            ST_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: shifters, carry, counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_carry  <= cin;
                        r_sum_sh <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_sum_sh <= {w_sum, r_sum_sh[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    // On the MSB cycle r_carry is the carry into the MSB,
                    // so carry-in XOR carry-out of that bit is signed overflow.
                    if (w_last) begin
                        r_sum  <= {w_sum, r_sum_sh[WIDTH-1:1]};
                        r_cout <= w_cout;
                        r_ovf  <= r_carry ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule
